// File: rtl/meter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | meter_pkg                                                                |
// | Shared palette, default geometry and small helpers for the meter panel.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package meter_pkg;

  localparam int DEF_N_CH        = 7;
  localparam int DEF_VOL_W       = 3;
  localparam int DEF_HOLD_FRAMES = 30;
  localparam int DEF_ORI_X       = 45;
  localparam int DEF_ORI_Y       = 380;
  localparam int DEF_PITCH       = 90;
  localparam int DEF_BOX_OUT     = 45;
  localparam int DEF_BOX_IN      = 40;
  localparam int DEF_BAR_X0      = 5;
  localparam int DEF_BAR_BASE_Y  = 420;
  localparam int DEF_BAR_W       = 80;
  localparam int DEF_UNIT_H      = 11;

  localparam logic [23:0] WHITE = 24'hFFFFFF;

  // {r, g, b}, indexed by (rot + channel) mod 8
  localparam logic [23:0] PALETTE [8] = '{
    24'hFFC0CB, 24'hFF00FF, 24'h872657, 24'hA020F0,
    24'h9933FA, 24'h87CEEB, 24'h00FFFF, 24'hBDFCC9
  };

  function automatic logic [2:0] rot_step(input logic [2:0] rot);
    logic [5:0] t;
    t = 6'(rot) * 6'd3 + 6'd5;
    return t[2:0];
  endfunction

  // a - b, with a negative result clamped to zero
  function automatic logic [12:0] sub_clamp(input logic [12:0] a, input logic [12:0] b);
    logic [13:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[13] ? 13'd0 : d[12:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/channel_meter_panel_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | meter_if                                                                 |
// | Pixel-pipeline and control signals of the channel meter panel.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface meter_if #(
  parameter int N_CH  = 7,
  parameter int VOL_W = 3
);
  localparam int SEL_W = $clog2(N_CH + 1);

  logic                    frame_start;
  logic [11:0]             CounterX;
  logic [11:0]             CounterY;
  logic [N_CH-1:0]         play;
  logic [N_CH*VOL_W-1:0]   vol_i;
  logic [SEL_W-1:0]        sel;
  logic                    peak_en;
  logic [7:0]              o_r;
  logic [7:0]              o_g;
  logic [7:0]              o_b;

  modport master (
    output frame_start, CounterX, CounterY, play, vol_i, sel, peak_en,
    input  o_r, o_g, o_b
  );

  modport slave (
    input  frame_start, CounterX, CounterY, play, vol_i, sel, peak_en,
    output o_r, o_g, o_b
  );
endinterface
`default_nettype wire

// File: rtl/meter_peak_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | meter_peak_tracker                                                       |
// | One channel's frame-latched volume and peak-hold/decay state.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module meter_peak_tracker #(
  parameter int VOL_W       = 3,
  parameter int HOLD_FRAMES = 30
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_tick,
  input  wire logic             i_play,
  input  wire logic [VOL_W-1:0] i_vol,
  output logic      [VOL_W-1:0] o_disp,
  output logic      [VOL_W-1:0] o_peak
);
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  logic [VOL_W-1:0]  r_disp;
  logic [VOL_W-1:0]  r_peak;
  logic [HOLD_W-1:0] r_hold;
  logic [VOL_W-1:0]  w_peak_dec;

  // only reached when peak > vol, so peak - 1 cannot wrap
  assign w_peak_dec = r_peak - 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_disp <= '0;
      r_peak <= '0;
      r_hold <= '0;
    end else if (i_tick) begin
      if (!i_play) begin
        r_disp <= '0;
        r_peak <= '0;
        r_hold <= '0;
      end else begin
        r_disp <= i_vol;
        if (i_vol >= r_peak) begin
          r_peak <= i_vol;
          r_hold <= HOLD_W'(HOLD_FRAMES);
        end else if (r_hold != '0) begin
          r_hold <= r_hold - 1'b1;
        end else begin
          r_peak <= (w_peak_dec > i_vol) ? w_peak_dec : i_vol;
        end
      end
    end
  end

  assign o_disp = r_disp;
  assign o_peak = r_peak;
endmodule
`default_nettype wire

// File: rtl/channel_meter_panel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | channel_meter_panel                                                      |
// | Lower-screen VGA overlay: per-channel box ring, volume bar, peak marker. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module channel_meter_panel
  import meter_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int VOL_W       = DEF_VOL_W,
  parameter int HOLD_FRAMES = DEF_HOLD_FRAMES,
  parameter int ORI_X       = DEF_ORI_X,
  parameter int ORI_Y       = DEF_ORI_Y,
  parameter int PITCH       = DEF_PITCH,
  parameter int BOX_OUT     = DEF_BOX_OUT,
  parameter int BOX_IN      = DEF_BOX_IN,
  parameter int BAR_X0      = DEF_BAR_X0,
  parameter int BAR_BASE_Y  = DEF_BAR_BASE_Y,
  parameter int BAR_W       = DEF_BAR_W,
  parameter int UNIT_H      = DEF_UNIT_H
) (
  input wire logic clk,
  input wire logic reset,
  meter_if.slave   bus
);
  localparam int SEL_W = $clog2(N_CH + 1);
  localparam logic [12:0] C_OY     = 13'(ORI_Y);
  localparam logic [12:0] C_BOUT   = 13'(BOX_OUT);
  localparam logic [12:0] C_BIN    = 13'(BOX_IN);
  localparam logic [12:0] C_BASE   = 13'(BAR_BASE_Y);
  localparam logic [12:0] C_UNIT   = 13'(UNIT_H);
  localparam logic [12:0] C_BARW   = 13'(BAR_W);
  localparam logic [12:0] C_SEL_LO = 13'(ORI_Y + BOX_OUT);

  logic [2:0]      r_rot;
  logic [12:0]     w_x;
  logic [12:0]     w_y;
  logic            w_y_out;
  logic            w_y_in;
  logic            w_y_sel;
  logic [N_CH-1:0] w_ring;
  logic [N_CH-1:0] w_bar;
  logic [N_CH-1:0] w_pk;
  logic [N_CH-1:0] w_sel;
  logic [23:0]     w_pix;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               r_rot <= 3'd0;
    else if (bus.frame_start) r_rot <= rot_step(r_rot);
  end

  assign w_x = {1'b0, bus.CounterX};
  assign w_y = {1'b0, bus.CounterY};

  // vertical windows are common to every channel
  assign w_y_out = (w_y + C_BOUT >= C_OY) && (w_y <= C_OY + C_BOUT);
  assign w_y_in  = (w_y + C_BIN  >= C_OY) && (w_y <= C_OY + C_BIN);
  assign w_y_sel = (w_y >= C_SEL_LO) && (w_y <= C_SEL_LO + 13'd5);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    localparam logic [12:0] C_CX = 13'(ORI_X + g * PITCH);
    localparam logic [12:0] C_BX = 13'(BAR_X0 + g * PITCH);

    logic [VOL_W-1:0] w_disp;
    logic [VOL_W-1:0] w_peak;
    logic [12:0]      w_bar_top;
    logic [12:0]      w_pk_top;
    logic             w_x_out;
    logic             w_x_in;
    logic             w_x_bar;

    meter_peak_tracker #(
      .VOL_W       (VOL_W),
      .HOLD_FRAMES (HOLD_FRAMES)
    ) u_trk (
      .clk    (clk),
      .reset  (reset),
      .i_tick (bus.frame_start),
      .i_play (bus.play[g]),
      .i_vol  (bus.vol_i[g*VOL_W +: VOL_W]),
      .o_disp (w_disp),
      .o_peak (w_peak)
    );

    assign w_bar_top = sub_clamp(C_BASE, C_UNIT * 13'(w_disp));
    assign w_pk_top  = sub_clamp(C_BASE, C_UNIT * 13'(w_peak));
    assign w_x_out   = (w_x + C_BOUT >= C_CX) && (w_x <= C_CX + C_BOUT);
    assign w_x_in    = (w_x + C_BIN  >= C_CX) && (w_x <= C_CX + C_BIN);
    assign w_x_bar   = (w_x >= C_BX) && (w_x <= C_BX + C_BARW);

    assign w_ring[g] = bus.play[g] && w_x_out && w_y_out && !(w_x_in && w_y_in);
    assign w_bar[g]  = bus.play[g] && (w_disp != '0) && w_x_bar
                       && (w_y >= w_bar_top) && (w_y <= C_BASE);
    assign w_pk[g]   = bus.peak_en && bus.play[g] && (w_peak != '0) && w_x_bar
                       && ((w_y == w_pk_top) || (w_y == w_pk_top + 13'd1));
    assign w_sel[g]  = (bus.sel == SEL_W'(g + 1)) && w_x_out && w_y_sel;
  end

  // later channels and later layers overwrite earlier ones
  always_comb begin
    w_pix = 24'h0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_ring[i] || w_bar[i]) w_pix = PALETTE[r_rot + 3'(i)];
      if (w_pk[i] || w_sel[i])   w_pix = WHITE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.o_r <= 8'd0;
      bus.o_g <= 8'd0;
      bus.o_b <= 8'd0;
    end else begin
      bus.o_r <= w_pix[23:16];
      bus.o_g <= w_pix[15:8];
      bus.o_b <= w_pix[7:0];
    end
  end
endmodule
`default_nettype wire
